canal_lock_ctrl: RTL

- Parametrised lock-chamber controller for one canal lock between an outer and an inner waterway.
- Owns the chamber water level, both gates, and the full gondola transit sequence, with hard interlocks enforced in every mode.
- Adds configurable levels and steps, timed gate motion, an automatic transit mode with request queuing, a manual mode, and fault reporting.
- Sits between the switch/key input decode and the display/LED driver.

---
 rtl/canal_lock_ctrl.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/canal_lock_ctrl.sv
// Canal lock chamber controller: water level, two timed gates, automatic
// transit sequencing with per-side request latching, manual mode and fault latch.
module canal_lock_ctrl #(
    parameter int WIDTH       = 8,
    parameter int OUTER_LEVEL = 73,
    parameter int INNER_LEVEL = 49,
    parameter int RESET_LEVEL = 52,
    parameter int FILL_STEP   = 2,
    parameter int DRAIN_STEP  = 2,
    parameter int GATE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_auto,
    input  logic             req_outer,
    input  logic             req_inner,
    input  logic             gondola_in,
    input  logic             gondola_out,
    input  logic             man_fill,
    input  logic             man_drain,
    input  logic             man_outer,
    input  logic             man_inner,
    output logic [WIDTH-1:0] lock_level,
    output logic             outer_open,
    output logic             inner_open,
    output logic             gate_moving,
    output logic             busy,
    output logic [3:0]       state,
    output logic             transit_done,
    output logic             fault
);

    localparam logic [WIDTH-1:0] OUT_L  = WIDTH'(OUTER_LEVEL);
    localparam logic [WIDTH-1:0] IN_L   = WIDTH'(INNER_LEVEL);
    localparam logic [WIDTH-1:0] RST_L  = WIDTH'(RESET_LEVEL);
    localparam logic [WIDTH-1:0] F_STEP = WIDTH'(FILL_STEP);
    localparam logic [WIDTH-1:0] D_STEP = WIDTH'(DRAIN_STEP);
    localparam int               CW     = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CW-1:0]    CNT_LOAD = CW'(GATE_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        EQ_ENTRY    = 4'd1,
        OPEN_ENTRY  = 4'd2,
        WAIT_IN     = 4'd3,
        CLOSE_ENTRY = 4'd4,
        EQ_EXIT     = 4'd5,
        OPEN_EXIT   = 4'd6,
        WAIT_OUT    = 4'd7,
        CLOSE_EXIT  = 4'd8,
        DONE        = 4'd9
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic             outer_q, outer_d, inner_q, inner_d;
    logic             mov_q, mov_d, mov_outer_q, mov_outer_d, mov_open_q, mov_open_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_outer_q, pend_outer_d, pend_inner_q, pend_inner_d;
    logic             entry_outer_q, entry_outer_d;
    logic             busy_q, busy_d, done_q, done_d, fault_q, fault_d;

    logic             st_go, st_outer, st_open, lvl_go, lvl_fire, flag_upd;
    logic [WIDTH-1:0] lvl_tgt, entry_lvl, exit_lvl;
    logic             entry_flag, exit_flag;
    logic             can_open_o, can_open_i, can_close_o, can_close_i;

    always_comb begin
        entry_lvl   = entry_outer_q ? OUT_L : IN_L;
        exit_lvl    = entry_outer_q ? IN_L : OUT_L;
        entry_flag  = entry_outer_q ? outer_q : inner_q;
        exit_flag   = entry_outer_q ? inner_q : outer_q;
        can_open_o  = !mov_q && !outer_q && !inner_q && (level_q == OUT_L);
        can_open_i  = !mov_q && !inner_q && !outer_q && (level_q == IN_L);
        can_close_o = !mov_q && outer_q;
        can_close_i = !mov_q && inner_q;
    end

    // Sequencing; every gate start below is already interlock-qualified.
    always_comb begin
        state_d       = state_q;
        entry_outer_d = entry_outer_q;
        pend_outer_d  = pend_outer_q;
        pend_inner_d  = pend_inner_q;
        st_go         = 1'b0;
        st_outer      = 1'b0;
        st_open       = 1'b0;
        lvl_go        = 1'b0;
        lvl_tgt       = level_q;
        if (fault_q) begin
            state_d = IDLE;
        end else begin
            if (state_q != IDLE) begin
                if (req_outer) pend_outer_d = 1'b1;
                if (req_inner) pend_inner_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (mode_auto) begin
                        if (req_outer || pend_outer_q) begin
                            state_d       = EQ_ENTRY;
                            entry_outer_d = 1'b1;
                            pend_outer_d  = 1'b0;
                            if (req_inner) pend_inner_d = 1'b1;
                        end else if (req_inner || pend_inner_q) begin
                            state_d       = EQ_ENTRY;
                            entry_outer_d = 1'b0;
                            pend_inner_d  = 1'b0;
                        end
                    end else begin
                        if (man_outer ? can_open_o : can_close_o) begin
                            st_go    = 1'b1;
                            st_outer = 1'b1;
                            st_open  = man_outer;
                        end else if (man_inner ? can_open_i : can_close_i) begin
                            st_go   = 1'b1;
                            st_open = man_inner;
                        end
                        if (man_fill) begin
                            lvl_go  = 1'b1;
                            lvl_tgt = OUT_L;
                        end else if (man_drain) begin
                            lvl_go  = 1'b1;
                            lvl_tgt = IN_L;
                        end
                    end
                end
                EQ_ENTRY: begin
                    if (level_q == entry_lvl) state_d = OPEN_ENTRY;
                    else begin
                        lvl_go  = 1'b1;
                        lvl_tgt = entry_lvl;
                    end
                end
                OPEN_ENTRY: begin
                    if (!mov_q && entry_flag) state_d = WAIT_IN;
                    else if (entry_outer_q ? can_open_o : can_open_i) begin
                        st_go    = 1'b1;
                        st_outer = entry_outer_q;
                        st_open  = 1'b1;
                    end
                end
                WAIT_IN: if (gondola_in) state_d = CLOSE_ENTRY;
                CLOSE_ENTRY: begin
                    if (!mov_q && !entry_flag) state_d = EQ_EXIT;
                    else if (entry_outer_q ? can_close_o : can_close_i) begin
                        st_go    = 1'b1;
                        st_outer = entry_outer_q;
                    end
                end
                EQ_EXIT: begin
                    if (level_q == exit_lvl) state_d = OPEN_EXIT;
                    else begin
                        lvl_go  = 1'b1;
                        lvl_tgt = exit_lvl;
                    end
                end
                OPEN_EXIT: begin
                    if (!mov_q && exit_flag) state_d = WAIT_OUT;
                    else if (entry_outer_q ? can_open_i : can_open_o) begin
                        st_go    = 1'b1;
                        st_outer = !entry_outer_q;
                        st_open  = 1'b1;
                    end
                end
                WAIT_OUT: if (gondola_out) state_d = CLOSE_EXIT;
                CLOSE_EXIT: begin
                    if (!mov_q && !exit_flag) state_d = DONE;
                    else if (entry_outer_q ? can_close_i : can_close_o) begin
                        st_go    = 1'b1;
                        st_outer = !entry_outer_q;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        lvl_fire = lvl_go && !st_go && !mov_q && !outer_q && !inner_q;
        level_d  = level_q;
        if (lvl_fire) begin
            if (level_q < lvl_tgt)
                level_d = (lvl_tgt - level_q < F_STEP) ? lvl_tgt : level_q + F_STEP;
            else if (level_q > lvl_tgt)
                level_d = (level_q - lvl_tgt < D_STEP) ? lvl_tgt : level_q - D_STEP;
        end

        // The open flag flips one cycle before motion ends, i.e. on the last motion cycle.
        mov_d       = mov_q;
        mov_outer_d = mov_outer_q;
        mov_open_d  = mov_open_q;
        cnt_d       = cnt_q;
        outer_d     = outer_q;
        inner_d     = inner_q;
        flag_upd    = 1'b0;
        if (st_go) begin
            mov_d       = 1'b1;
            mov_outer_d = st_outer;
            mov_open_d  = st_open;
            cnt_d       = CNT_LOAD;
            flag_upd    = (GATE_CYCLES == 1);
        end else if (mov_q && !fault_q) begin
            if (cnt_q == '0) mov_d = 1'b0;
            else cnt_d = cnt_q - 1'b1;
            flag_upd = (cnt_q == CW'(1));
        end
        if (flag_upd) begin
            if (mov_outer_d) outer_d = mov_open_d;
            else inner_d = mov_open_d;
        end

        fault_d = fault_q || (outer_q && inner_q) || (level_q < IN_L) || (level_q > OUT_L);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            level_q       <= RST_L;
            outer_q       <= 1'b0;
            inner_q       <= 1'b0;
            mov_q         <= 1'b0;
            mov_outer_q   <= 1'b0;
            mov_open_q    <= 1'b0;
            cnt_q         <= '0;
            pend_outer_q  <= 1'b0;
            pend_inner_q  <= 1'b0;
            entry_outer_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            outer_q       <= outer_d;
            inner_q       <= inner_d;
            mov_q         <= mov_d;
            mov_outer_q   <= mov_outer_d;
            mov_open_q    <= mov_open_d;
            cnt_q         <= cnt_d;
            pend_outer_q  <= pend_outer_d;
            pend_inner_q  <= pend_inner_d;
            entry_outer_q <= entry_outer_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
        end
    end

    assign lock_level   = level_q;
    assign outer_open   = outer_q;
    assign inner_open   = inner_q;
    assign gate_moving  = mov_q;
    assign busy         = busy_q;
    assign state        = state_q;
    assign transit_done = done_q;
    assign fault        = fault_q;

endmodule
